uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's baud-clocked transmitter.
- Recovers 8N1 frames (start bit, 8 data bits LSB-first, 1 stop bit) from the asynchronous rx line using oversampling on baud_clk.
- Holds each received byte in a one-entry buffer with a valid/ack handshake and reports framing and overrun errors.
- Drives rts so the remote transmitter can pause while the buffer is full.

Parameters:
- OVERSAMPLE, 16, baud_clk cycles per bit period; must be even and >= 4.
- SYNC_STAGES, 2, flops in the rx input synchronizer; must be >= 2.

Ports:
- rst  input  1  asynchronous reset, active-high.
- baud_clk  input  1  clock, OVERSAMPLE x bit rate. All state updates on the posedge.
- rx  input  1  serial line, idle high, asynchronous to baud_clk.
- data_out  output  8  last accepted byte.
- data_valid  output  1  data_out holds an unread byte.
- data_ack  input  1  consumer read strobe; only meaningful while data_valid=1.
- frame_err  output  1  stop bit of the byte in data_out was sampled 0.
- overrun  output  1  sticky; a completed byte was dropped because the buffer was full.
- rts  output  1  ready-to-receive; equals ~data_valid.

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, overrun=0, rts=1.
  - Synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame discards the partial byte immediately.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. The FSM uses only rx_s.
- FSM states:
  - IDLE: when rx_s==0, go to START with tick=0.
  - START:
    - tick increments each cycle.
    - At tick==OVERSAMPLE/2-1 with rx_s==0: go to DATA, tick=0, bit_cnt=0.
    - At tick==OVERSAMPLE/2-1 with rx_s==1: go to IDLE as a glitch; no output change.
  - DATA:
    - tick increments each cycle.
    - At tick==OVERSAMPLE-1: shift rx_s into the MSB of shift_reg (right shift), tick=0, bit_cnt+=1.
    - After the 8th sample (bit_cnt was 7): go to STOP.
  - STOP: at tick==OVERSAMPLE-1, sample rx_s as the stop bit and perform the commit below.
    - Next state is IDLE if rx_s==1.
    - Next state is WAIT_IDLE if rx_s==0 (break or framing error).
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. No new start is detected while in this state.
- Commit (single cycle):
  - Buffer free: data_valid==0, or data_ack==1 in the same cycle. Load data_out=shift_reg, frame_err=~rx_s, data_valid=1.
  - Buffer full with no ack: data_out, frame_err and data_valid are unchanged; set overrun=1; the byte is dropped.
- Handshake:
  - data_valid && data_ack with no commit: data_valid=0 and overrun=0 on the next edge. data_out and frame_err keep their values.
  - data_ack while data_valid==0 is ignored.
  - An ack coincident with a commit clears the old overrun; it does not set overrun. The new byte is presented.
- Latency:
  - rx falls at edge r.
  - rx_s goes low at r+SYNC_STAGES.
  - data_valid is high after edge r + SYNC_STAGES + OVERSAMPLE/2 + 9*OVERSAMPLE + 1, i.e. r+155 for the defaults.
- Bit sampling is at mid-bit relative to the detected start edge; no majority vote.
- rts is combinational from the data_valid register.

Decomposition:
- Shared package uart_pkg:
  - localparam UART_DATA_BITS=8.
  - typedef enum logic [2:0] uart_rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE}.
  - Usable by the transmitter.
- Sub-module uart_sync: parameterized SYNC_STAGES flop chain with asynchronous reset to 1. Reusable for the transmitter's cts input.

Test Plan (OVERSAMPLE=16, SYNC_STAGES=2, ideal bit period of 16 cycles):
- Send 0xA5 with stop=1 -> data_valid rises 155 cycles after the rx falling edge; data_out=0xA5, frame_err=0, rts=0. Then ack -> data_valid=0 and rts=1 next cycle.
- Drive rx low for 4 cycles, then high -> FSM returns to IDLE; data_valid stays 0; a following 0x3C frame is received correctly.
- Send 0x3C with stop=0, rx held low 40 more cycles -> data_out=0x3C, frame_err=1; FSM stays in WAIT_IDLE and detects no start until rx goes high; a following 0x11 frame (after ack) is received with frame_err=0.
- Send 0x01 then 0x02 with no ack -> data_out=0x01 and overrun=1 after the second frame; ack -> data_valid=0, overrun=0.
- Send 0x55 and hold it unread; send 0xAA with data_ack asserted exactly on its commit cycle -> data_out=0xAA, data_valid stays 1, overrun=0.
- Assert rst during bit 4 of 0xFF -> all outputs at reset values; rx idles, then 0x81 is sent -> data_out=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Holds the data width and the receiver state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous serial line.
// Resets to 1 so an idle-high line produces no spurious edge.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-entry output buffer,
// framing/overrun reporting and rts flow control.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rst,
  input  logic       baud_clk,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       rts
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(UART_DATA_BITS - 1);

  logic w_rx_s;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .baud_clk(baud_clk),
    .rst     (rst),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  uart_rx_state_t            r_state;
  uart_rx_state_t            w_state_nxt;
  logic [TW-1:0]             r_tick;
  logic [TW-1:0]             w_tick_nxt;
  logic [BW-1:0]             r_bit_cnt;
  logic [BW-1:0]             w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      w_commit;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_commit    = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = RX_START;
          w_tick_nxt  = '0;
        end
      end
      RX_START: begin
        if (r_tick == HALF) begin
          w_tick_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt = RX_DATA;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      RX_DATA: begin
        if (r_tick == FULL) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
          w_bit_nxt   = r_bit_cnt + BW'(1);
          if (r_bit_cnt == LAST) begin
            w_state_nxt = RX_STOP;
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      RX_STOP: begin
        if (r_tick == FULL) begin
          w_tick_nxt  = '0;
          w_commit    = 1'b1;
          w_state_nxt = w_rx_s ? RX_IDLE : RX_WAIT_IDLE;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ferr;
  logic       r_overrun;
  logic       w_free;

  // An ack in the commit cycle frees the slot for the incoming byte.
  assign w_free = !r_valid || data_ack;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_commit) begin
      if (w_free) begin
        r_data  <= r_shift;
        r_ferr  <= ~w_rx_s;
        r_valid <= 1'b1;
        if (data_ack) begin
          r_overrun <= 1'b0;
        end
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && data_ack) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign rts        = ~r_valid;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus handshake/error sequences,
// with a scoreboard checking every byte the receiver presents.
module tb_uart_rx;

  logic       rst = 1'b1;
  logic       baud_clk = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       rts;

  uart_rx #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .rst       (rst),
    .baud_clk  (baud_clk),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rts       (rts)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t sb[$];

  int   start_cyc = 0;
  int   load_cyc = -1000;
  logic p_valid = 1'b0;
  logic p_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // A new byte is presented when valid rises, or stays high across an ack.
  always @(negedge baud_clk) begin
    exp_t e;
    if (!rst && data_valid && (!p_valid || p_ack)) begin
      load_cyc = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h, expected none", data_out);
      end else begin
        e = sb.pop_front();
        chk("sb_data", {24'd0, data_out}, {24'd0, e.d});
        chk("sb_frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
    p_valid = data_valid;
    p_ack   = data_ack;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input int ack_off, input int ncyc, input logic tail);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int c = 0; c < ncyc; c++) begin
      rx = fr[c/16];
      data_ack = (c == ack_off);
      @(posedge baud_clk);
      #1;
    end
    rx = tail;
    data_ack = 1'b0;
  endtask

  task automatic ack();
    data_ack = 1'b1;
    @(posedge baud_clk);
    #1;
    data_ack = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_rts"}, {31'd0, rts}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       fe;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b0};
    vt[1] = '{8'h00, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h96, 1'b0, 1'b1};

    rst = 1'b1;
    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 4; i++) begin
      sb.push_back('{vt[i].d, vt[i].fe});
      send(vt[i].d, vt[i].stop, -1, 160, 1'b1);
      tick(5);
      chk("latency", load_cyc - start_cyc, 32'd155);
      chk("vec_valid", {31'd0, data_valid}, 32'd1);
      chk("vec_rts", {31'd0, rts}, 32'd0);
      ack();
      chk("vec_ack_valid", {31'd0, data_valid}, 32'd0);
      chk("vec_ack_rts", {31'd0, rts}, 32'd1);
      tick(20);
    end

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    chk("glitch_valid", {31'd0, data_valid}, 32'd0);
    sb.push_back('{8'h3C, 1'b0});
    send(8'h3C, 1'b1, -1, 160, 1'b1);
    tick(5);
    chk("glitch_next_valid", {31'd0, data_valid}, 32'd1);
    ack();
    tick(10);

    sb.push_back('{8'h3C, 1'b1});
    send(8'h3C, 1'b0, -1, 160, 1'b0);
    tick(40);
    chk("brk_valid", {31'd0, data_valid}, 32'd1);
    rx = 1'b1;
    tick(200);
    chk("brk_no_start", {31'd0, overrun}, 32'd0);
    chk("brk_still_valid", {31'd0, data_valid}, 32'd1);
    ack();
    tick(10);
    sb.push_back('{8'h11, 1'b0});
    send(8'h11, 1'b1, -1, 160, 1'b1);
    tick(5);
    chk("after_brk_valid", {31'd0, data_valid}, 32'd1);
    ack();
    tick(10);

    sb.push_back('{8'h01, 1'b0});
    send(8'h01, 1'b1, -1, 160, 1'b1);
    tick(20);
    send(8'h02, 1'b1, -1, 160, 1'b1);
    tick(5);
    chk("ovr_data", {24'd0, data_out}, 32'h01);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, data_valid}, 32'd1);
    ack();
    chk("ovr_ack_valid", {31'd0, data_valid}, 32'd0);
    chk("ovr_ack_flag", {31'd0, overrun}, 32'd0);
    tick(10);

    sb.push_back('{8'h55, 1'b0});
    send(8'h55, 1'b1, -1, 160, 1'b1);
    tick(20);
    sb.push_back('{8'hAA, 1'b0});
    send(8'hAA, 1'b1, 154, 160, 1'b1);
    tick(2);
    chk("ackc_data", {24'd0, data_out}, 32'hAA);
    chk("ackc_valid", {31'd0, data_valid}, 32'd1);
    chk("ackc_overrun", {31'd0, overrun}, 32'd0);
    chk("ackc_rts", {31'd0, rts}, 32'd0);

    send(8'hFF, 1'b1, -1, 88, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    tick(3);
    rst = 1'b0;
    tick(20);
    sb.push_back('{8'h81, 1'b0});
    send(8'h81, 1'b1, -1, 160, 1'b1);
    tick(5);
    chk("post_rst_valid", {31'd0, data_valid}, 32'd1);
    chk("post_rst_latency", load_cyc - start_cyc, 32'd155);
    ack();
    tick(20);

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
